// File: rtl/rv32i_types.sv
// Shared datapath constants for the cache hierarchy.
// A line is 256 bits; the low 5 address bits select a byte within the line,
// and the remaining 27 bits form the line tag used for all matching.
// Ports: none (package only).
package rv32i_types;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = 32 - OFFSET_W;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [TAG_W-1:0]  tag_t;

    // Strip the byte offset from a full address.
    function automatic tag_t addr_tag(input logic [31:0] addr);
        return addr[31:OFFSET_W];
    endfunction

    // Rebuild a line-aligned address from a tag.
    function automatic logic [31:0] tag_addr(input tag_t tag);
        return {tag, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/victim_buffer_cam.sv
// Entry storage and fully associative tag match for the victim buffer.
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset (clears valid bits)
//   wr_en_i/idx/tag/line write one entry and mark it valid
//   inv_en_i/inv_idx_i  clear the valid bit of one entry
//   lookup_tag_i        tag to search for
//   hit_o/hit_idx_o/hit_line_o  match result (lowest matching index wins)
//   rd_idx_i/rd_tag_o/rd_line_o direct read port (used for the FIFO head)
module victim_buffer_cam
    import rv32i_types::*;
#(
    parameter int  DEPTH = 4,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  tag_t             wr_tag_i,
    input  line_t            wr_line_i,
    input  logic             inv_en_i,
    input  logic [IDX_W-1:0] inv_idx_i,
    input  tag_t             lookup_tag_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] hit_idx_o,
    output line_t            hit_line_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    output tag_t             rd_tag_o,
    output line_t            rd_line_o
);

    logic [DEPTH-1:0] valid_q;
    tag_t             tag_q  [DEPTH];
    line_t            line_q [DEPTH];

    // Valid bits are the only state that reset must clear; a write to the
    // same index as an invalidate in the same cycle leaves the entry valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            if (inv_en_i) valid_q[inv_idx_i] <= 1'b0;
            if (wr_en_i)  valid_q[wr_idx_i]  <= 1'b1;
        end
    end

    // Tag and line payload carry no reset; they are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end
    end

    // Tags are kept unique by the controller, so at most one entry matches.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

    assign hit_line_o = line_q[hit_idx_o];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/victim_buffer.sv
// Write-back victim buffer sitting between the cache arbiter (mem_*) and the
// cacheline adaptor (pmem_*). Evicted lines are parked in a small FIFO, reads
// that hit a parked line are answered locally, and parked lines are written
// downstream whenever the upstream side is quiet or the FIFO is full.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mem_read/mem_write           upstream requests, held until mem_resp
//   mem_address/mem_wdata        upstream line address and write line
//   mem_rdata/mem_resp           registered read line and one-cycle completion
//   pmem_read/pmem_write         downstream requests, held until pmem_resp
//   pmem_address/pmem_wdata      downstream line address (offset zero) and line
//   pmem_rdata/pmem_resp         downstream read line and completion pulse
module victim_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  line_t       mem_wdata,
    output line_t       mem_rdata,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output line_t       pmem_wdata,
    input  line_t       pmem_rdata,
    input  logic        pmem_resp
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        MEM_READ,
        DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    line_t            rdata_q, rdata_d;
    tag_t             req_tag_q, req_tag_d;

    logic             cam_wr_en;
    logic [IDX_W-1:0] cam_wr_idx;
    logic             cam_inv_en;
    logic             cam_hit;
    logic [IDX_W-1:0] cam_hit_idx;
    line_t            cam_hit_line;
    tag_t             head_tag;
    line_t            head_line;

    tag_t             req_tag;
    logic             full;
    logic             unused_offset;

    assign req_tag       = addr_tag(mem_address);
    assign full          = (count_q == CNT_W'(DEPTH));
    assign unused_offset = ^mem_address[OFFSET_W-1:0];

    victim_buffer_cam #(
        .DEPTH(DEPTH)
    ) u_cam (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en_i      (cam_wr_en),
        .wr_idx_i     (cam_wr_idx),
        .wr_tag_i     (req_tag),
        .wr_line_i    (mem_wdata),
        .inv_en_i     (cam_inv_en),
        .inv_idx_i    (head_q),
        .lookup_tag_i (req_tag),
        .hit_o        (cam_hit),
        .hit_idx_o    (cam_hit_idx),
        .hit_line_o   (cam_hit_line),
        .rd_idx_i     (head_q),
        .rd_tag_o     (head_tag),
        .rd_line_o    (head_line)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rdata_q   <= '0;
            req_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
            req_tag_q <= req_tag_d;
        end
    end

    // Upstream requests are only examined in IDLE, so a drain that has
    // started always runs to completion before the next request is seen.
    // A full buffer with a non-matching write drains the head first and
    // then picks the write up again on the following IDLE cycle.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rdata_d    = rdata_q;
        req_tag_d  = req_tag_q;
        cam_wr_en  = 1'b0;
        cam_wr_idx = tail_q;
        cam_inv_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_read) begin
                    if (cam_hit) begin
                        rdata_d = cam_hit_line;
                        state_d = RESP;
                    end else begin
                        req_tag_d = req_tag;
                        state_d   = MEM_READ;
                    end
                end else if (mem_write) begin
                    if (cam_hit) begin
                        cam_wr_en  = 1'b1;
                        cam_wr_idx = cam_hit_idx;
                        state_d    = RESP;
                    end else if (!full) begin
                        cam_wr_en = 1'b1;
                        tail_d    = tail_q + 1'b1;
                        count_d   = count_q + 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            MEM_READ: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    cam_inv_en = 1'b1;
                    head_d     = head_q + 1'b1;
                    count_d    = count_q - 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode straight from the state register so that an
    // asynchronous reset removes them in the same cycle.
    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == MEM_READ) begin
            pmem_address = tag_addr(req_tag_q);
        end else if (state_q == DRAIN) begin
            pmem_address = tag_addr(head_tag);
            pmem_wdata   = head_line;
        end
    end

    assign mem_resp   = (state_q == RESP);
    assign pmem_read  = (state_q == MEM_READ);
    assign pmem_write = (state_q == DRAIN);
    assign mem_rdata  = rdata_q;

endmodule

// File: tb/tb_victim_buffer.sv
// Self-checking bench for victim_buffer. A behavioural FIFO of parked lines
// predicts what must be drained downstream and what a read must return; the
// bench also plays the downstream memory with a programmable response delay.
module tb_victim_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] line;
    } entry_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int           checks = 0;
    int           errors = 0;

    entry_t       model[$];
    int           respLatency = 1;
    int           respWait = 0;
    int           drainCount = 0;
    logic [31:0]  lastDrainAddr;
    logic [255:0] lastDrainData;
    bit           readSeen;
    logic [31:0]  readAddr;
    logic [255:0] readLine;
    logic [31:0]  curAddr;

    victim_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic int findTag(input logic [26:0] tag);
        foreach (model[i]) if (model[i].tag == tag) return i;
        return -1;
    endfunction

    // Downstream memory: answers after respLatency cycles, checks every
    // drain against the oldest parked line and supplies fresh read data.
    initial begin : pmemResponder
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n || pmem_resp) begin
                pmem_resp = 1'b0;
                respWait  = 0;
            end else if (pmem_read || pmem_write) begin
                checks++;
                if (pmem_read && pmem_write) begin
                    errors++;
                    $display("[TB] FAIL pmem_exclusive: read=%b write=%b, required not both", pmem_read, pmem_write);
                end
                checks++;
                if (pmem_address[4:0] !== 5'd0) begin
                    errors++;
                    $display("[TB] FAIL pmem_align: addr=%h, required offset 0", pmem_address);
                end
                respWait++;
                if (respWait >= respLatency) begin
                    pmem_resp = 1'b1;
                    respWait  = 0;
                    if (pmem_write) begin
                        drainCount++;
                        lastDrainAddr = pmem_address;
                        lastDrainData = pmem_wdata;
                        checks++;
                        if (model.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL drain_unexpected: addr=%h with no parked line", pmem_address);
                        end else begin
                            if (pmem_address !== {model[0].tag, 5'd0} || pmem_wdata !== model[0].line) begin
                                errors++;
                                $display("[TB] FAIL drain_order: got addr=%h data=%h, expected addr=%h data=%h",
                                         pmem_address, pmem_wdata, {model[0].tag, 5'd0}, model[0].line);
                            end
                            model.delete(0);
                        end
                    end else begin
                        for (int k = 0; k < 8; k++) readLine[k*32 +: 32] = $urandom();
                        pmem_rdata = readLine;
                        readSeen   = 1'b1;
                        readAddr   = pmem_address;
                        checks++;
                        if (pmem_address !== {curAddr[31:5], 5'd0}) begin
                            errors++;
                            $display("[TB] FAIL read_addr: got %h, expected %h", pmem_address, {curAddr[31:5], 5'd0});
                        end
                    end
                end
            end
        end
    end

    task automatic applyReset();
        reset_n     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        repeat (2) @(negedge clk);
        model.delete();
        drainCount  = 0;
        respLatency = 1;
        reset_n     = 1'b1;
    endtask

    // Issues one upstream request, holds it until mem_resp, and folds an
    // accepted write into the model. cycles counts negedges until mem_resp.
    task automatic applyStimulus(input bit isRead, input logic [31:0] addr, input logic [255:0] wdata,
                                 output int cycles, output logic [255:0] rdata);
        int idx;
        curAddr     = addr;
        readSeen    = 1'b0;
        mem_read    = isRead;
        mem_write   = !isRead;
        mem_address = addr;
        mem_wdata   = wdata;
        cycles      = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!mem_resp && cycles < 300);
        rdata     = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!mem_resp) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_timeout: addr=%h read=%b, no mem_resp in %0d cycles", addr, isRead, cycles);
        end else if (!isRead) begin
            idx = findTag(addr[31:5]);
            if (idx >= 0) begin
                model[idx].line = wdata;
            end else begin
                checks++;
                if (model.size() >= DEPTH) begin
                    errors++;
                    $display("[TB] FAIL write_overflow: accepted addr=%h with %0d lines parked, limit %0d",
                             addr, model.size(), DEPTH);
                end
                model.push_back('{addr[31:5], wdata});
            end
        end
    endtask

    task automatic test_reset();
        int           cyc;
        logic [255:0] rd;
        logic [255:0] lineX = {8{32'h1234_5678}};
        applyReset();
        applyStimulus(0, 32'h0000_0040, lineX, cyc, rd);
        applyStimulus(1, 32'h0000_0040, '0, cyc, rd);
        checks++;
        if (rd !== lineX) begin
            errors++;
            $display("[TB] FAIL reset_prefill_hit: rdata=%h, expected %h", rd, lineX);
        end
        respLatency = 50;
        curAddr     = 32'h0000_0080;
        mem_address = 32'h0000_0080;
        mem_read    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pre_read: pmem_read=%b, expected 1", pmem_read);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: resp=%b pr=%b pw=%b addr=%h, expected all 0",
                     mem_resp, pmem_read, pmem_write, pmem_address);
        end
        checks++;
        if (mem_rdata !== '0 || pmem_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: rdata=%h wdata=%h, expected 0", mem_rdata, pmem_wdata);
        end
        mem_read = 1'b0;
        model.delete();
        @(negedge clk);
        reset_n     = 1'b1;
        respLatency = 1;
        applyStimulus(1, 32'h0000_0040, '0, cyc, rd);
        checks++;
        if (!readSeen || rd !== readLine) begin
            errors++;
            $display("[TB] FAIL reset_drops_lines: pmem_read_seen=%b rdata=%h, expected miss with %h",
                     readSeen, rd, readLine);
        end
    endtask

    task automatic test_write_then_read_hit();
        int           cyc;
        logic [255:0] rd;
        logic [255:0] lineA = {8{32'hAAAA_0001}};
        applyReset();
        applyStimulus(0, 32'h0000_0100, lineA, cyc, rd);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("[TB] FAIL write_latency: %0d cycles, expected 1", cyc);
        end
        applyStimulus(1, 32'h0000_0100, '0, cyc, rd);
        checks++;
        if (rd !== lineA || readSeen || cyc != 2) begin
            errors++;
            $display("[TB] FAIL read_hit: rdata=%h pmem_read_seen=%b cycles=%0d, expected %h, 0, 2",
                     rd, readSeen, cyc, lineA);
        end
    endtask

    task automatic test_read_miss();
        int           cyc;
        logic [255:0] rd;
        applyReset();
        respLatency = 2;
        applyStimulus(1, 32'h0000_0200, '0, cyc, rd);
        checks++;
        if (!readSeen || readAddr !== 32'h0000_0200 || rd !== readLine || cyc != 3) begin
            errors++;
            $display("[TB] FAIL read_miss: seen=%b addr=%h rdata=%h cycles=%0d, expected 1, 00000200, %h, 3",
                     readSeen, readAddr, rd, cyc, readLine);
        end
    endtask

    task automatic test_coalesce();
        int           cyc;
        logic [255:0] rd;
        logic [255:0] lineC = {8{32'hCCCC_0003}};
        logic [255:0] lineD = {8{32'hDDDD_0004}};
        applyReset();
        applyStimulus(0, 32'h0000_0300, lineC, cyc, rd);
        applyStimulus(0, 32'h0000_0310, lineD, cyc, rd);
        repeat (10) @(negedge clk);
        checks++;
        if (drainCount != 1 || lastDrainAddr !== 32'h0000_0300 || lastDrainData !== lineD) begin
            errors++;
            $display("[TB] FAIL coalesce: drains=%0d addr=%h data=%h, expected 1, 00000300, %h",
                     drainCount, lastDrainAddr, lastDrainData, lineD);
        end
    endtask

    task automatic test_full_drain();
        int           cyc;
        logic [255:0] rd;
        logic [255:0] lines[5];
        for (int i = 0; i < 5; i++) lines[i] = {8{32'hF000_0000 + i}};
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'(i * 32), lines[i], cyc, rd);
        applyStimulus(0, 32'h0000_0080, lines[4], cyc, rd);
        checks++;
        if (drainCount != 1 || lastDrainAddr !== 32'd0 || cyc != 4) begin
            errors++;
            $display("[TB] FAIL full_drain: drains=%0d addr=%h cycles=%0d, expected 1, 00000000, 4",
                     drainCount, lastDrainAddr, cyc);
        end
        applyStimulus(1, 32'h0000_0020, '0, cyc, rd);
        checks++;
        if (rd !== lines[1] || readSeen) begin
            errors++;
            $display("[TB] FAIL full_hit_old: rdata=%h seen=%b, expected %h, 0", rd, readSeen, lines[1]);
        end
        applyStimulus(1, 32'h0000_0080, '0, cyc, rd);
        checks++;
        if (rd !== lines[4] || readSeen) begin
            errors++;
            $display("[TB] FAIL full_hit_new: rdata=%h seen=%b, expected %h, 0", rd, readSeen, lines[4]);
        end
    endtask

    task automatic test_read_during_drain();
        int           cyc;
        int           guard;
        logic [255:0] rd;
        logic [255:0] lineA = {8{32'h5A5A_0010}};
        applyReset();
        respLatency = 3;
        applyStimulus(0, 32'h0000_0000, lineA, cyc, rd);
        guard = 0;
        while (!pmem_write && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        applyStimulus(1, 32'h0000_0000, '0, cyc, rd);
        checks++;
        if (drainCount != 1 || lastDrainData !== lineA) begin
            errors++;
            $display("[TB] FAIL drain_before_read: drains=%0d data=%h, expected 1, %h", drainCount, lastDrainData, lineA);
        end
        checks++;
        if (!readSeen || readAddr !== 32'd0 || rd !== readLine) begin
            errors++;
            $display("[TB] FAIL read_after_drain: seen=%b addr=%h rdata=%h, expected 1, 00000000, %h",
                     readSeen, readAddr, rd, readLine);
        end
    endtask

    task automatic test_reset_mid_drain();
        int           cyc;
        int           guard;
        int           drainsBefore;
        logic [255:0] rd;
        applyReset();
        respLatency = 50;
        applyStimulus(0, 32'h0000_0140, {8{32'hEEEE_0005}}, cyc, rd);
        guard = 0;
        while (!pmem_write && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || pmem_address !== 32'd0 || pmem_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_drain: pw=%b addr=%h, expected 0, 00000000", pmem_write, pmem_address);
        end
        model.delete();
        @(negedge clk);
        reset_n      = 1'b1;
        respLatency  = 1;
        drainsBefore = drainCount;
        applyStimulus(1, 32'h0000_0140, '0, cyc, rd);
        checks++;
        if (!readSeen || readAddr !== 32'h0000_0140) begin
            errors++;
            $display("[TB] FAIL drained_tag_misses: seen=%b addr=%h, expected 1, 00000140", readSeen, readAddr);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (drainCount != drainsBefore) begin
            errors++;
            $display("[TB] FAIL empty_after_reset: drains=%0d, expected %0d", drainCount, drainsBefore);
        end
    endtask

    task automatic test_random();
        int           cyc;
        int           idx;
        int           guard;
        logic [255:0] rd;
        logic [255:0] wd;
        logic [31:0]  addr;
        bit           isRead;
        applyReset();
        for (int n = 0; n < 150; n++) begin
            respLatency = $urandom_range(1, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            addr = 32'(($urandom_range(0, 7) << 5) | $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) addr = addr | 32'hF000_0000;
            isRead = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom();
            applyStimulus(isRead, addr, wd, cyc, rd);
            if (isRead) begin
                idx = findTag(addr[31:5]);
                checks++;
                if (readSeen) begin
                    if (idx >= 0 || rd !== readLine) begin
                        errors++;
                        $display("[TB] FAIL rand_read_miss: addr=%h parked=%0d rdata=%h, expected not parked, %h",
                                 addr, idx, rd, readLine);
                    end
                end else if (idx < 0 || rd !== model[idx].line) begin
                    errors++;
                    $display("[TB] FAIL rand_read_hit: addr=%h parked=%0d rdata=%h", addr, idx, rd);
                end
            end
        end
        guard = 0;
        while (model.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (model.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_final_drain: %0d lines never drained, expected 0", model.size());
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        curAddr     = '0;
        readSeen    = 1'b0;
        test_reset();
        test_write_then_read_hit();
        test_read_miss();
        test_coalesce();
        test_full_drain();
        test_read_during_drain();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
